// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: bounded saturating (or wrapping) count, prescaled events, load.
// Define UDCNT_WRAP_EN to wrap at the bounds instead of holding in LIMIT.
module updown_counter_param #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] MIN_VAL  = '0,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1,
    parameter logic [WIDTH-1:0] STEP     = WIDTH'(1),
    parameter int unsigned      PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             u,
    input  logic             d,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] c_out,
    output logic             m,
    output logic             z,
    output logic [1:0]       dir,
    output logic             wrap
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_UP    = 2'b01,
        S_DOWN  = 2'b10,
        S_LIMIT = 2'b11
    } state_t;

    localparam int unsigned    PCW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);
    localparam logic [WIDTH:0] MAX_X   = {1'b0, MAX_VAL};
    localparam logic [WIDTH:0] MIN_X   = {1'b0, MIN_VAL};
    localparam logic [WIDTH:0] STEP_X  = {1'b0, STEP};

    state_t           state_q, state_d, tgt;
    logic [PCW-1:0]   pc_q, pc_d, pc_cur;
    logic [WIDTH-1:0] cnt_q, cnt_d, up_val, dn_val, ld_val;
    logic             m_q, z_q;
    logic             req_up, req_dn, up_over, dn_under;
    logic [WIDTH:0]   cnt_x, up_x, dn_x;

    assign req_up = u & ~d;
    assign req_dn = d & ~u;

    // One spare bit keeps cnt+STEP from overflowing before the bound test.
    assign cnt_x    = {1'b0, cnt_q};
    assign up_x     = cnt_x + STEP_X;
    assign dn_x     = cnt_x - STEP_X;
    assign up_over  = up_x > MAX_X;
    assign dn_under = cnt_x < (MIN_X + STEP_X);

`ifdef UDCNT_WRAP_EN
    logic wrap_q, wrap_d;
    assign up_val = up_over  ? MIN_VAL : up_x[WIDTH-1:0];
    assign dn_val = dn_under ? MAX_VAL : dn_x[WIDTH-1:0];
`else
    assign up_val = up_over  ? MAX_VAL : up_x[WIDTH-1:0];
    assign dn_val = dn_under ? MIN_VAL : dn_x[WIDTH-1:0];
`endif

    assign ld_val = (load_val < MIN_VAL) ? MIN_VAL :
                    (load_val > MAX_VAL) ? MAX_VAL : load_val;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        tgt     = S_IDLE;
        pc_cur  = '0;
`ifdef UDCNT_WRAP_EN
        wrap_d  = 1'b0;
`endif
        if (load) begin
            cnt_d   = ld_val;
            state_d = S_IDLE;
            pc_d    = '0;
        end else if (!req_up && !req_dn) begin
            state_d = S_IDLE;
            pc_d    = '0;
`ifndef UDCNT_WRAP_EN
        end else if ((req_up && cnt_q == MAX_VAL) || (req_dn && cnt_q == MIN_VAL)) begin
            state_d = S_LIMIT;
            pc_d    = '0;
`endif
        end else begin
            tgt     = req_up ? S_UP : S_DOWN;
            state_d = tgt;
            // Entering a direction (from any other state) restarts the prescale period.
            pc_cur  = (state_q == tgt) ? pc_q : '0;
            if (pc_cur == PC_LAST) begin
                pc_d  = '0;
                cnt_d = req_up ? up_val : dn_val;
`ifdef UDCNT_WRAP_EN
                wrap_d = req_up ? up_over : dn_under;
`else
                if (cnt_d == (req_up ? MAX_VAL : MIN_VAL))
                    state_d = S_LIMIT;
`endif
            end else begin
                pc_d = pc_cur + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= MIN_VAL;
            m_q     <= 1'b0;
            z_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            m_q     <= (cnt_d == MAX_VAL);
            z_q     <= (cnt_d == MIN_VAL);
        end
    end

`ifdef UDCNT_WRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wrap_q <= 1'b0;
        else        wrap_q <= wrap_d;
    end
    assign wrap = wrap_q;
`else
    assign wrap = 1'b0;
`endif

    assign c_out = cnt_q;
    assign m     = m_q;
    assign z     = z_q;
    assign dir   = state_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: directed vector table, hand sequences and a randomized model check.
module tb_updown_counter_param;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ua = 0, da = 0, lda = 0;
    logic [3:0]  lva = '0;
    logic [3:0]  ca;
    logic        ma, za, wa;
    logic [1:0]  dira;
    logic        ub = 0, db = 0, ldb = 0;
    logic [15:0] lvb = '0;
    logic [15:0] cb;
    logic        mb, zb, wb;
    logic [1:0]  dirb;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .MIN_VAL(4'd2), .MAX_VAL(4'd9), .STEP(4'd3), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset), .u(ua), .d(da), .load(lda), .load_val(lva),
        .c_out(ca), .m(ma), .z(za), .dir(dira), .wrap(wa));

    updown_counter_param #(.WIDTH(16), .PRESCALE(3)) dut_b (
        .clk(clk), .reset(reset), .u(ub), .d(db), .load(ldb), .load_val(lvb),
        .c_out(cb), .m(mb), .z(zb), .dir(dirb), .wrap(wb));

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: counts consecutive cycles spent requesting one direction.
    typedef struct {
        longint c;
        int     dir;
        int     run;
        bit     w;
    } mst_t;

    function automatic mst_t mstep(mst_t s, bit u, bit d, bit ld, longint lv,
                                   longint mn, longint mx, longint st, int ps);
        mst_t n = s;
        int want;
        n.w = 0;
        if (ld) begin
            n.c = (lv < mn) ? mn : ((lv > mx) ? mx : lv);
            n.dir = 0; n.run = 0;
            return n;
        end
        if (u == d) begin
            n.dir = 0; n.run = 0;
            return n;
        end
`ifndef UDCNT_WRAP_EN
        if ((u && s.c == mx) || (d && s.c == mn)) begin
            n.dir = 3; n.run = 0;
            return n;
        end
`endif
        want = u ? 1 : 2;
        if (s.dir != want) n.run = 0;
        n.dir = want;
        n.run = n.run + 1;
        if (n.run % ps == 0) begin
            if (u) begin
                if (s.c + st > mx) begin
`ifdef UDCNT_WRAP_EN
                    n.c = mn; n.w = 1;
`else
                    n.c = mx;
`endif
                end else n.c = s.c + st;
            end else begin
                if (s.c - st < mn) begin
`ifdef UDCNT_WRAP_EN
                    n.c = mx; n.w = 1;
`else
                    n.c = mn;
`endif
                end else n.c = s.c - st;
            end
`ifndef UDCNT_WRAP_EN
            if (n.c == (u ? mx : mn)) n.dir = 3;
`endif
        end
        return n;
    endfunction

    typedef struct {
        bit       u, d, ld;
        bit [3:0] lv;
        bit [3:0] c;
        bit [1:0] dir;
        bit       m, z, w;
    } vec_t;

    vec_t tbl[$];

    initial begin
        mst_t sa, sb;
        int   k;

`ifdef UDCNT_WRAP_EN
        tbl.push_back('{1, 0, 0, 4'd0,  4'd5, 2'b01, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 4'd0,  4'd8, 2'b01, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 4'd0,  4'd2, 2'b01, 0, 1, 1});
        tbl.push_back('{1, 0, 0, 4'd0,  4'd5, 2'b01, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 4'd6,  4'd6, 2'b00, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 4'd0,  4'd9, 2'b01, 1, 0, 0});
        tbl.push_back('{1, 0, 0, 4'd0,  4'd2, 2'b01, 0, 1, 1});
        tbl.push_back('{0, 0, 1, 4'd3,  4'd3, 2'b00, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 4'd0,  4'd9, 2'b10, 1, 0, 1});
        tbl.push_back('{0, 1, 0, 4'd0,  4'd6, 2'b10, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 4'd0,  4'd3, 2'b10, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 4'd0,  4'd9, 2'b10, 1, 0, 1});
        tbl.push_back('{1, 1, 1, 4'd5,  4'd5, 2'b00, 0, 0, 0});
`else
        tbl.push_back('{1, 0, 0, 4'd0,  4'd5, 2'b01, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 4'd0,  4'd8, 2'b01, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 4'd0,  4'd9, 2'b11, 1, 0, 0});
        tbl.push_back('{1, 0, 0, 4'd0,  4'd9, 2'b11, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 4'd0,  4'd6, 2'b10, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 4'd0,  4'd3, 2'b10, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 4'd0,  4'd2, 2'b11, 0, 1, 0});
        tbl.push_back('{0, 1, 0, 4'd0,  4'd2, 2'b11, 0, 1, 0});
        tbl.push_back('{1, 0, 1, 4'd15, 4'd9, 2'b00, 1, 0, 0});
        tbl.push_back('{1, 0, 0, 4'd0,  4'd9, 2'b11, 1, 0, 0});
        tbl.push_back('{0, 1, 1, 4'd0,  4'd2, 2'b00, 0, 1, 0});
        tbl.push_back('{0, 1, 0, 4'd0,  4'd2, 2'b11, 0, 1, 0});
        tbl.push_back('{1, 1, 1, 4'd5,  4'd5, 2'b00, 0, 0, 0});
`endif

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_c", ca, 2);   chk("rst_a_z", za, 1); chk("rst_a_m", ma, 0); chk("rst_a_dir", dira, 0);
        chk("rst_b_c", cb, 0);   chk("rst_b_z", zb, 1); chk("rst_b_dir", dirb, 0); chk("rst_b_w", wb, 0);
        reset = 1'b1;

        // Prescaler 3: one count event every third edge
        ub = 1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk($sformatf("presc_e%0d", e), cb, e / 3);
        end
        ub = 0;
        tick();

        // Direction flip at edge 7 restarts the 3-edge period
        ldb = 1; lvb = 16'd0; tick(); ldb = 0;
        ub = 1;
        for (int e = 1; e <= 6; e++) tick();
        chk("flip_pre", cb, 2);
        ub = 0; db = 1;
        tick(); chk("flip_e7", cb, 2);
        tick(); chk("flip_e8", cb, 2);
        tick(); chk("flip_e9", cb, 1); chk("flip_dir", dirb, 2);
        db = 0;

        // Directed vector table on the 2..9 / step 3 instance
        foreach (tbl[i]) begin
            ua = tbl[i].u; da = tbl[i].d; lda = tbl[i].ld; lva = tbl[i].lv;
            tick();
            chk($sformatf("tbl%0d_c", i), ca, tbl[i].c);
            chk($sformatf("tbl%0d_dir", i), dira, tbl[i].dir);
            chk($sformatf("tbl%0d_mz", i), {ma, za}, {tbl[i].m, tbl[i].z});
            chk($sformatf("tbl%0d_w", i), wa, tbl[i].w);
        end
        lda = 0;

        // Hold at 5 with u==d for 20 cycles
        for (int e = 0; e < 20; e++) begin
            ua = e[0]; da = e[0];
            tick();
            chk($sformatf("hold%0d", e), {ca, dira}, {4'd5, 2'b00});
        end

        // Asynchronous reset mid-count, checked before any clock edge
        ldb = 1; lvb = 16'h0123; tick(); ldb = 0;
        ub = 1; ua = 1; da = 0;
        tick(); tick();
        #2 reset = 1'b0;
        #1;
        chk("amid_b_c", cb, 0); chk("amid_b_z", zb, 1); chk("amid_b_m", mb, 0); chk("amid_b_dir", dirb, 0);
        chk("amid_a_c", ca, 2); chk("amid_a_dir", dira, 0);
        ua = 0; ub = 0;
        tick();
        reset = 1'b1;

        // Randomized run against the model
        sa = '{c: 2, dir: 0, run: 0, w: 0};
        sb = '{c: 0, dir: 0, run: 0, w: 0};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            k = int'($urandom_range(0, 15));
            ua = $urandom_range(0, 3) != 0 ? k[0] : 1'b1;
            da = k[1] & ~k[0] | (k == 15);
            lda = ($urandom_range(0, 15) == 0);
            lva = 4'($urandom);
            k = int'($urandom_range(0, 63));
            ub = k < 40; db = (k >= 30 && k < 55);
            ldb = ($urandom_range(0, 31) == 0);
            lvb = $urandom_range(0, 1) ? 16'($urandom_range(0, 12)) : 16'($urandom);
            if ($urandom_range(0, 7) == 0) lvb = 16'hFFFF;
            sa = mstep(sa, ua, da, lda, lva, 2, 9, 3, 1);
            sb = mstep(sb, ub, db, ldb, lvb, 0, 65535, 1, 3);
            tick();
            chk("rnd_a_c", ca, sa.c);
            chk("rnd_a_dir", dira, sa.dir);
            chk("rnd_a_mz", {ma, za}, {sa.c == 9, sa.c == 2});
            chk("rnd_a_w", wa, sa.w);
            chk("rnd_b_c", cb, sb.c);
            chk("rnd_b_dir", dirb, sb.dir);
            chk("rnd_b_mz", {mb, zb}, {sb.c == 65535, sb.c == 0});
            chk("rnd_b_w", wb, sb.w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised up/down counter with configurable width, limits, step and prescaler, plus synchronous load and limit flags. It is the next-generation counting core for `top_system`, replacing the fixed 16-bit saturating `u`/`d` counter. It adds programmable bounds, an optional wrap mode and registered at-limit status. It sits directly behind the user direction inputs and drives the count bus to the display/consumer logic.

## Interface
- `WIDTH`, 16, count bus width (2..32)
- `MIN_VAL`, 0, lower count bound; must satisfy MIN_VAL < MAX_VAL
- `MAX_VAL`, 2**WIDTH-1, upper count bound; must fit in WIDTH bits
- `STEP`, 1, increment/decrement amount per count event; 1 <= STEP <= MAX_VAL-MIN_VAL
- `PRESCALE`, 1, enabled cycles per count event (>=1)

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `u`  in  1  count-up request
- `d`  in  1  count-down request
- `load`  in  1  synchronous load strobe
- `load_val`  in  WIDTH  value to load
- `c_out`  out  WIDTH  current count
- `m`  out  1  high while c_out == MAX_VAL
- `z`  out  1  high while c_out == MIN_VAL
- `dir`  out  2  FSM state: 00 IDLE, 01 UP, 10 DOWN, 11 LIMIT
- `wrap`  out  1  one-cycle pulse on wrap-around (only with the configuration macro)

## Operation
- Request decode, evaluated each cycle:
  - u=1, d=0 → up.
  - u=0, d=1 → down.
  - u==d → none; count holds.
- FSM, all registered:
  - IDLE: no request.
  - UP / DOWN: counting toward a limit.
  - LIMIT: saturated at the limit in the requested direction; count holds.
  - Any state → IDLE when there is no request.
  - IDLE/DOWN/LIMIT → UP on an up request when c_out != MAX_VAL; IDLE/UP/LIMIT → DOWN on a down request when c_out != MIN_VAL.
  - UP → LIMIT when the step reaches MAX_VAL; DOWN → LIMIT when the step reaches MIN_VAL.
  - LIMIT exits only on a request that moves away from the limit.
- Prescaler:
  - Internal counter `pc` in 0..PRESCALE-1 advances each cycle in UP/DOWN, or on the cycle a request enters UP/DOWN.
  - A count event occurs when `pc` == PRESCALE-1; `pc` then returns to 0.
  - `pc` clears on IDLE, LIMIT, direction change and load.
- Arithmetic:
  - Computed in WIDTH+1 bits.
  - Up: next = c_out+STEP; if next >= MAX_VAL, clamp to MAX_VAL.
  - Down: if c_out < MIN_VAL+STEP, clamp to MIN_VAL; otherwise next = c_out-STEP.
  - No overflow of the bus is possible.
- Load has priority over counting:
  - c_out <= clamp(load_val, MIN_VAL, MAX_VAL).
  - FSM → IDLE; prescaler cleared.
  - Counting resumes on the next cycle if a request is present.
- `m` and `z` are registered and updated on the same edge as `c_out`; they are never both high.

## Timing
- Reset (reset=0, asynchronous): c_out=MIN_VAL, z=1, m=0, dir=00, wrap=0, pc=0.
- Reset release: the first edge with reset=1 samples requests normally. A reset asserted mid-count forces the reset values immediately, with no clock needed.
- Count latency with PRESCALE=1: c_out changes on the first rising edge at which the request is sampled. In general, the first change occurs PRESCALE edges after the request is first sampled, then every PRESCALE edges.
- Load: c_out shows the clamped value on the edge that samples load=1.
- Requests are level-sensitive; glitch-free inputs are the caller's responsibility (no synchroniser inside).
- u=d=1 is treated as no request: count holds, FSM goes to IDLE.

## Configuration
- `UDCNT_WRAP_EN` undefined (default): saturating mode as above; `wrap` is tied 0.
- `UDCNT_WRAP_EN` defined: there is no LIMIT hold.
  - Up when c_out+STEP > MAX_VAL → c_out=MIN_VAL.
  - Down when c_out < MIN_VAL+STEP → c_out=MAX_VAL.
  - Landing exactly on a bound is not a wrap.
  - `wrap` pulses high for exactly one cycle on the same edge as the wrapped c_out.
  - FSM never enters LIMIT (dir stays 01/10).

## Test plan
- Reset: assert reset=0 mid-count at c_out=0x0123 → c_out=0, z=1, m=0, dir=00 without a clock edge.
- Up saturation (WIDTH=4, MIN=2, MAX=9, STEP=3, PRESCALE=1): from 2, u=1 → 5, 8, 9, then holds 9 with m=1, dir=11. Switching to d=1 → 6, 3, 2, z=1.
- Prescaler (PRESCALE=3, STEP=1, default bounds): u=1 for 10 cycles from 0 → c_out=1, 2, 3 at edges 3, 6, 9. A direction flip at edge 7 restarts the 3-cycle count.
- Load priority: load=1, load_val=15, u=1 with MAX=9 → c_out=9, m=1, dir=00. load_val=0 with MIN=2 → c_out=2, z=1.
- u=d=1 and u=d=0 for 20 cycles at c_out=5 → c_out stays 5, dir=00.
- With `UDCNT_WRAP_EN` (WIDTH=4, MIN=2, MAX=9, STEP=3): up from 8 → 2 with a one-cycle wrap pulse. Down from 3 → 9 with a wrap pulse. Up from 6 → 9 with no wrap pulse.
